itof_pipe: RTL
==============

// Module: itof_pipe
// PURPOSE
//  Parametrised, pipelined integer-to-IEEE-754 single-precision converter for the FPU.
//  - Takes a signed or unsigned INT_W-bit integer with a tag and returns the binary32
//    value, rounded to nearest, ties to even.
//  - Fixed 3-cycle latency; valid/ready handshake with full backpressure.
//  - Sits between the FPU issue queue and the result writeback mux.
// PARAMETERS
//  INT_W  32  integer input width; legal range 2..64 (out of range: elaboration error)
//  TAG_W  5   sideband tag width (destination register id); passed through unchanged
// PORTS
//  clk          in   1      clock, rising edge
//  rstn         in   1      asynchronous active-low reset
//  in_valid     in   1      input operand valid
//  in_ready     out  1      converter can accept the operand this cycle
//  in_data      in   INT_W  integer operand
//  in_unsigned  in   1      1: in_data is unsigned; 0: two's complement
//  in_tag       in   TAG_W  sideband tag
//  out_valid    out  1      result valid
//  out_ready    in   1      consumer accepts the result this cycle
//  out_data     out  32     binary32 result {sign, exp[7:0], frac[22:0]}
//  out_tag      out  TAG_W  tag of this result
//  out_inexact  out  1      1 when rounding discarded nonzero bits
// BEHAVIOUR
//  - Reset (rstn=0, async): all stage valids, out_data, out_tag, out_inexact clear to 0.
//    In-flight operands are discarded. in_ready=1 from the first edge after release.
//  - Handshake: a transfer occurs on an edge where valid&&ready.
//    - Stage k loads when it is empty or stage k+1 loads/drains in the same cycle.
//    - in_ready = stage-1 load condition (combinational from out_ready allowed).
//    - Holding out_valid=1 with out_ready=0: out_data/out_tag/out_inexact stay stable.
//    - Results leave in issue order, exactly 3 cycles after acceptance with no stall.
//    - out_ready=1 permanently: throughput is 1 result per cycle.
//  - Stage 1 (register): sign = !in_unsigned && in_data[INT_W-1].
//    mag = sign ? -in_data : in_data, as an unsigned INT_W-bit value.
//    Signed minimum -2^(INT_W-1) gives mag=2^(INT_W-1).
//  - Stage 2 (register): p = index of the leading one of mag (priority encoder).
//    norm = mag << (INT_W-1-p), so the leading one is at norm[INT_W-1]. zero = (mag==0).
//  - Stage 3 (register): frac = norm[INT_W-2 -: 23], zero-padded on the right if INT_W<24.
//    - guard = next lower bit; sticky = OR of all remaining bits.
//    - Round up when guard && (sticky || frac[0]). out_inexact = guard || sticky.
//    - Rounding carry out of frac: frac=0, exponent+1.
//    - exp = 127 + p (+1 on carry); max 191, so no overflow or inf is possible.
//  - zero: out_data = 32'h00000000 (never -0), out_inexact=0.
//  - INT_W <= 24: conversion is always exact (out_inexact=0).
// TESTING
//  - Reset, INT_W=32: send signed 1, then -1 -> 32'h3F800000, 32'hBF800000 on
//    consecutive cycles, 3 cycles after acceptance.
//  - Send signed 0, signed 32'h80000000, unsigned 32'hFFFFFFFF
//    -> 32'h00000000, 32'hCF000000, 32'h4F800000 (last has inexact=1).
//  - Ties: 16777217 -> 32'h4B800000 inexact=1; 16777219 -> 32'h4B800002 inexact=1.
//  - Backpressure: 8 back-to-back tagged ops, out_ready toggled randomly
//    -> all 8 delivered in order, no loss or duplication, outputs stable while stalled.
//  - Reset mid-stream: assert rstn=0 with 3 ops in flight
//    -> out_valid=0 at once, no stale result after release.
//  - Re-elaborate INT_W=16 and INT_W=64; sweep random values against a real-valued model.
//    Check signed 64'h8000000000000000 -> 32'hDF000000.

Source files
------------

// File: rtl/itof_pipe.sv
// Three-stage integer-to-binary32 converter (round to nearest, ties to even)
// with a valid/ready pipeline that supports full backpressure.
module itof_pipe #(
    parameter int INT_W = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [INT_W-1:0] in_data,
    input  logic             in_unsigned,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_inexact
);

    generate
        if (INT_W < 2 || INT_W > 64) begin : g_bad_width
            $error("itof_pipe: INT_W must be in 2..64");
        end
    endgenerate

    localparam int PW    = $clog2(INT_W);
    // Working width for rounding: at least 1 leading + 23 frac + guard + 1 sticky bit.
    localparam int EXT_W = (INT_W > 26) ? INT_W : 26;

    // Handshake state
    logic ld1, ld2, ld3;
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;

    // Stage 1: sign and magnitude
    logic             sign1_q, sign1_d;
    logic [INT_W-1:0] mag_q, mag_d;
    logic [TAG_W-1:0] tag1_q, tag1_d;

    // Stage 2: normalised magnitude
    logic             sign2_q, sign2_d;
    logic [PW-1:0]    p_q, p_d, p_raw, sh;
    logic [INT_W-1:0] norm_q, norm_d;
    logic [TAG_W-1:0] tag2_q, tag2_d;

    // Stage 3: rounded result
    logic [31:0]      out_data_q, out_data_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             out_inexact_q, out_inexact_d;

    logic [EXT_W-1:0] ext;
    logic [22:0]      frac;
    logic [23:0]      frac_r;
    logic             guard, sticky, rnd_up, carry, zero;
    logic [7:0]       expo;

    // NOTE: in_ready depends combinationally on out_ready so a full pipe can
    // accept a new operand in the same cycle its oldest result drains.
    always_comb begin
        ld3      = !v3_q || out_ready;
        ld2      = !v2_q || ld3;
        ld1      = !v1_q || ld2;
        in_ready = ld1;
        v1_d     = ld1 ? in_valid : v1_q;
        v2_d     = ld2 ? v1_q : v2_q;
        v3_d     = ld3 ? v2_q : v3_q;
    end

    always_comb begin
        sign1_d = sign1_q;
        mag_d   = mag_q;
        tag1_d  = tag1_q;
        if (ld1) begin
            sign1_d = !in_unsigned && in_data[INT_W-1];
            mag_d   = sign1_d ? -in_data : in_data;
            tag1_d  = in_tag;
        end
    end

    always_comb begin
        p_raw = '0;
        for (int i = 0; i < INT_W; i++) begin
            if (mag_q[i]) p_raw = PW'(i);
        end
        sh = PW'(INT_W - 1) - p_raw;

        sign2_d = sign2_q;
        p_d     = p_q;
        norm_d  = norm_q;
        tag2_d  = tag2_q;
        if (ld2) begin
            sign2_d = sign1_q;
            p_d     = p_raw;
            norm_d  = mag_q << sh;
            tag2_d  = tag1_q;
        end
    end

    always_comb begin
        ext                    = '0;
        ext[EXT_W-1 -: INT_W]  = norm_q;
        // A normalised value without its leading one means the operand was zero.
        zero   = !ext[EXT_W-1];
        frac   = ext[EXT_W-2 -: 23];
        guard  = ext[EXT_W-25];
        sticky = |ext[EXT_W-26:0];
        rnd_up = guard && (sticky || frac[0]);
        frac_r = {1'b0, frac} + 24'(rnd_up);
        carry  = frac_r[23];
        expo   = 8'd127 + 8'(p_q) + 8'(carry);

        out_data_d    = out_data_q;
        out_tag_d     = out_tag_q;
        out_inexact_d = out_inexact_q;
        if (ld3) begin
            out_data_d    = zero ? 32'h0000_0000
                                 : {sign2_q, expo, carry ? 23'd0 : frac_r[22:0]};
            out_tag_d     = tag2_q;
            out_inexact_d = !zero && (guard || sticky);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q          <= 1'b0;
            v2_q          <= 1'b0;
            v3_q          <= 1'b0;
            out_data_q    <= '0;
            out_tag_q     <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            v1_q          <= v1_d;
            v2_q          <= v2_d;
            v3_q          <= v3_d;
            out_data_q    <= out_data_d;
            out_tag_q     <= out_tag_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    // NOTE: inner pipeline data is qualified by its stage valid, so it needs no reset.
    always_ff @(posedge clk) begin
        sign1_q <= sign1_d;
        mag_q   <= mag_d;
        tag1_q  <= tag1_d;
        sign2_q <= sign2_d;
        p_q     <= p_d;
        norm_q  <= norm_d;
        tag2_q  <= tag2_d;
    end

    assign out_valid   = v3_q;
    assign out_data    = out_data_q;
    assign out_tag     = out_tag_q;
    assign out_inexact = out_inexact_q;

endmodule
